// File: rtl/debug_chan_mux.sv
// debug_chan_mux: N-channel debug bus multiplexer feeding one ILA probe port.
// Two-stage pipeline (capture all channels, then mux by the active select),
// a latched select with blanking on every channel switch, rejection of
// out-of-range selects, output freeze and a masked change-detect trigger.
// Optional trigger counter output enabled by defining DEBUG_CHAN_MUX_TRIGCNT_EN.
module debug_chan_mux #(
    parameter int NCH          = 4,
    parameter int WIDTH        = 71,
    parameter int SEL_WIDTH    = 2,
    parameter int BLANK_CYCLES = 4,
    parameter int DEFAULT_SEL  = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NCH*WIDTH-1:0]   dbg_i,
    input  logic [SEL_WIDTH-1:0]   sel_i,
    input  logic                   sel_wr_i,
    input  logic                   freeze_i,
    input  logic [WIDTH-1:0]       trig_mask_i,
    output logic [WIDTH-1:0]       dbg_o,
    output logic                   valid_o,
    output logic [SEL_WIDTH-1:0]   sel_o,
    output logic                   busy_o,
    output logic                   sel_err_o,
    output logic                   trig_o
`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
    ,
    output logic [15:0]            trig_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_ACTIVE = 1'b0,
        ST_BLANK  = 1'b1
    } state_t;

    // NCH widened by one bit so that NCH == 2**SEL_WIDTH still compares correctly.
    localparam logic [SEL_WIDTH:0] NCH_W     = (SEL_WIDTH+1)'(NCH);
    localparam logic [7:0]         BLANK_W   = 8'(BLANK_CYCLES);
    localparam logic [SEL_WIDTH-1:0] SEL_RST = SEL_WIDTH'(DEFAULT_SEL);

    logic [NCH*WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0]     stage2_s;
    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 sel_err_q, sel_err_d;
    logic [WIDTH-1:0]     dbg_q, dbg_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 trig_q, trig_d;
    logic                 in_range_s;
    logic                 switch_s;

    // Stage-1 capture of every channel, unconditionally.
    always_comb begin
        stage1_d = dbg_i;
    end

    // Stage-2 mux of the captured channels by the active select.
    always_comb begin
        stage2_s = '0;
        for (int k = 0; k < NCH; k++) begin
            stage2_s = stage2_s |
                       ((sel_q == SEL_WIDTH'(k)) ? stage1_q[k*WIDTH +: WIDTH] : {WIDTH{1'b0}});
        end
    end

    // Classify a select write: in range, and whether it changes channel.
    always_comb begin
        in_range_s = ({1'b0, sel_i} < NCH_W);
        switch_s   = sel_wr_i & in_range_s & (sel_i != sel_q);
    end

    // Select register and sticky error flag updates.
    always_comb begin
        sel_d     = sel_q;
        sel_err_d = sel_err_q;
        if (sel_wr_i) begin
            if (!in_range_s) begin
                sel_err_d = 1'b1;
            end else begin
                sel_err_d = 1'b0;
                sel_d     = sel_i;
            end
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // FSM next state: any accepted switch (re)starts the blanking countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                if (switch_s) begin
                    state_d = ST_BLANK;
                    cnt_d   = BLANK_W;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_BLANK: begin
                if (switch_s) begin
                    cnt_d = BLANK_W;
                end else if (cnt_q <= 8'd1) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = BLANK_W;
            end
        endcase
    end

    // Output datapath: blank, freeze-hold or live data plus change trigger.
    // The trigger needs a live baseline (valid_q), so the first ACTIVE cycle
    // after blanking only reloads the baseline and never fires.
    always_comb begin
        dbg_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        trig_d  = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (freeze_i) begin
                    dbg_d   = dbg_q;
                    valid_d = valid_q;
                end else begin
                    dbg_d   = stage2_s;
                    valid_d = 1'b1;
                    trig_d  = valid_q & (|((stage2_s ^ dbg_q) & trig_mask_i));
                end
            end
            ST_BLANK: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Pipeline, control and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1_q  <= '0;
            state_q   <= ST_BLANK;
            cnt_q     <= BLANK_W;
            sel_q     <= SEL_RST;
            sel_err_q <= 1'b0;
            dbg_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            trig_q    <= 1'b0;
        end else begin
            stage1_q  <= stage1_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            sel_err_q <= sel_err_d;
            dbg_q     <= dbg_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            trig_q    <= trig_d;
        end
    end

    assign dbg_o     = dbg_q;
    assign valid_o   = valid_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign sel_err_o = sel_err_q;
    assign trig_o    = trig_q;

`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
    logic [15:0] trig_cnt_q, trig_cnt_d;

    // Trigger counter: cleared on a channel switch, otherwise saturating count.
    always_comb begin
        trig_cnt_d = trig_cnt_q;
        if (switch_s) begin
            trig_cnt_d = 16'd0;
        end else if (trig_d && (trig_cnt_q != 16'hFFFF)) begin
            trig_cnt_d = trig_cnt_q + 16'd1;
        end else begin
            trig_cnt_d = trig_cnt_q;
        end
    end

    // Trigger counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            trig_cnt_q <= 16'd0;
        end else begin
            trig_cnt_q <= trig_cnt_d;
        end
    end

    assign trig_cnt_o = trig_cnt_q;
`endif

endmodule

// File: tb/tb_debug_chan_mux.sv
// Self-checking bench for debug_chan_mux (NCH=3, WIDTH=71, BLANK_CYCLES=4).
// Each row drives one cycle of stimulus and pushes the expected outputs for
// the following clock edge onto a scoreboard queue; the entry is popped and
// compared #1 after that edge.
module tb_debug_chan_mux;
    localparam int NCH = 3;
    localparam int W   = 71;
    localparam int SW  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH*W-1:0] dbg_i;
    logic [SW-1:0]   sel_i;
    logic            sel_wr_i;
    logic            freeze_i;
    logic [W-1:0]    trig_mask_i;
    logic [W-1:0]    dbg_o;
    logic            valid_o;
    logic [SW-1:0]   sel_o;
    logic            busy_o;
    logic            sel_err_o;
    logic            trig_o;
`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
    logic [15:0]     trig_cnt_o;
`endif

    debug_chan_mux #(.NCH(NCH), .WIDTH(W), .SEL_WIDTH(SW), .BLANK_CYCLES(4), .DEFAULT_SEL(0)) dut (
        .clk_i(clk), .rst_i(rst), .dbg_i(dbg_i), .sel_i(sel_i), .sel_wr_i(sel_wr_i),
        .freeze_i(freeze_i), .trig_mask_i(trig_mask_i), .dbg_o(dbg_o), .valid_o(valid_o),
        .sel_o(sel_o), .busy_o(busy_o), .sel_err_o(sel_err_o), .trig_o(trig_o)
`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
        , .trig_cnt_o(trig_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  sel;
        logic        frz;
        logic [1:0]  cidx;
        logic [70:0] cval;
        logic [70:0] edbg;
        logic        ev;
        logic        eb;
        logic        et;
        logic [1:0]  esel;
        logic        eerr;
    } row_t;

    typedef struct packed {
        logic [70:0] dbg;
        logic        v;
        logic        b;
        logic        t;
        logic [1:0]  sel;
        logic        err;
    } exp_t;

    exp_t sb[$];
    row_t rows[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [70:0] C0 = 71'h5A;
    localparam logic [70:0] C1 = 71'h777;
    localparam logic [70:0] C2 = 71'h123;
    localparam logic [70:0] Z  = 71'h0;

    function automatic row_t mk(input logic wr, input logic [1:0] sel, input logic frz,
                                input logic [1:0] cidx, input logic [70:0] cval,
                                input logic [70:0] edbg, input logic ev, input logic eb,
                                input logic et, input logic [1:0] esel, input logic eerr);
        row_t r;
        r.wr = wr; r.sel = sel; r.frz = frz; r.cidx = cidx; r.cval = cval;
        r.edbg = edbg; r.ev = ev; r.eb = eb; r.et = et; r.esel = esel; r.eerr = eerr;
        return r;
    endfunction

    function automatic logic [77:0] observed();
        return {dbg_o, valid_o, busy_o, trig_o, sel_o, sel_err_o};
    endfunction

    // Drive one row of stimulus and record its expected result.
    task automatic apply(input row_t r);
        exp_t e;
        sel_wr_i = r.wr;
        sel_i    = r.sel;
        freeze_i = r.frz;
        dbg_i[r.cidx*W +: W] = r.cval;
        e.dbg = r.edbg; e.v = r.ev; e.b = r.eb; e.t = r.et; e.sel = r.esel; e.err = r.eerr;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; sel_wr_i = 1'b0; sel_i = '0; freeze_i = 1'b0; trig_mask_i = '0;
        dbg_i = '0;
        dbg_i[0*W +: W] = C0; dbg_i[1*W +: W] = C1; dbg_i[2*W +: W] = C2;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (observed() !== 78'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", observed(), 78'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL reset_release row %0d: got %h expected %h", i, observed(), e);
            end
        end
        rows.delete();
    endtask

    task automatic test_switch();
        exp_t e;
        rows.push_back(mk(1'b1, 2'd2, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd2, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0));
        rows.push_back(mk(1'b0, 2'd2, 1'b0, 2'd0, C0, C2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        rows.push_back(mk(1'b0, 2'd2, 1'b0, 2'd0, C0, C2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL switch row %0d: got %h expected %h", i, observed(), e);
            end
        end
        rows.delete();
    endtask

    task automatic test_sel_err();
        exp_t e;
        rows.push_back(mk(1'b1, 2'd3, 1'b0, 2'd1, C1, C2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1));
        for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd1, C1, C2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1));
        rows.push_back(mk(1'b1, 2'd1, 1'b0, 2'd1, C1, C2, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, C1, Z, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, C1, C1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b1, 2'd3, 1'b0, 2'd1, C1, C1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1));
        // Same-channel write only clears the error; no blanking follows.
        rows.push_back(mk(1'b1, 2'd1, 1'b0, 2'd1, C1, C1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, C1, C1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, C1, C1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL sel_err row %0d: got %h expected %h", i, observed(), e);
            end
        end
        rows.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        rows.push_back(mk(1'b1, 2'd0, 1'b0, 2'd0, C0, C1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b1, 2'd1, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b1, 2'd2, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd2, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0));
        rows.push_back(mk(1'b0, 2'd2, 1'b0, 2'd0, C0, C2, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL back_to_back row %0d: got %h expected %h", i, observed(), e);
            end
        end
        rows.delete();
    endtask

    task automatic test_trigger_freeze();
        exp_t e;
        trig_mask_i = 71'h1;
        rows.push_back(mk(1'b1, 2'd0, 1'b0, 2'd0, C0, C2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, Z, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, C0, C0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        // bit0 toggle: pulse two cycles after the change
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h5B, C0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h5B, 71'h5B, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h5B, 71'h5B, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        // bit1 toggle: masked out, no pulse
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h59, 71'h5B, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h59, 71'h59, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h59, 71'h59, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        // frozen bit0 toggle: output held, no pulse
        for (int i = 0; i < 3; i++) rows.push_back(mk(1'b0, 2'd0, 1'b1, 2'd0, 71'h58, 71'h59, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        // release: new data next edge, compared against the held live word
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h58, 71'h58, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0));
        rows.push_back(mk(1'b0, 2'd0, 1'b0, 2'd0, 71'h58, 71'h58, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL trigger_freeze row %0d: got %h expected %h", i, observed(), e);
            end
        end
        rows.delete();
    endtask

    task automatic test_trig_count();
        exp_t e;
        logic [70:0] v;
        logic [70:0] prev;
        rows.push_back(mk(1'b1, 2'd1, 1'b0, 2'd1, C1, 71'h58, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        for (int i = 0; i < 4; i++) rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, C1, Z, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0));
        rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, C1, C1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
        prev = C1;
        for (int k = 0; k < 5; k++) begin
            v = prev ^ 71'h1;
            rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, v, prev, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0));
            rows.push_back(mk(1'b0, 2'd1, 1'b0, 2'd1, v, v, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0));
            prev = v;
        end
        foreach (rows[i]) begin
            apply(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL trig_count row %0d: got %h expected %h", i, observed(), e);
            end
        end
        rows.delete();
`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
        checks++;
        if (trig_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL trig_cnt_five: got %0d expected 5", trig_cnt_o);
        end
`endif
        apply(mk(1'b1, 2'd2, 1'b0, 2'd1, prev, prev, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0));
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL trig_count_switch: got %h expected %h", observed(), e);
        end
`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
        checks++;
        if (trig_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL trig_cnt_clear: got %0d expected 0", trig_cnt_o);
        end
`endif
        sel_wr_i = 1'b0;
    endtask

    task automatic test_reset_mid_switch();
        @(posedge clk); #1;
        sel_wr_i = 1'b1; sel_i = 2'd0;
        @(posedge clk); #1;
        sel_wr_i = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (observed() !== 78'h0) begin
            errors++;
            $display("FAIL reset_mid_switch: got %h expected %h", observed(), 78'h0);
        end
`ifdef DEBUG_CHAN_MUX_TRIGCNT_EN
        checks++;
        if (trig_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_trig_cnt: got %0d expected 0", trig_cnt_o);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_switch();
        test_sel_err();
        test_back_to_back();
        test_trigger_freeze();
        test_trig_count();
        test_reset_mid_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_chan_mux.md
Name: debug_chan_mux

Overview:
- Parametrised N-channel debug multiplexer. Feeds one ILA probe port from NCH equal-width debug buses.
- Adds a latched select register, a blanking sequence on channel switch, out-of-range select rejection, freeze, and a masked change-detect trigger.
- Sits between subsystem debug buses and the ILA. Runs in the ILA clock domain. The select comes from a VIO/wishbone register already synchronised to clk_i.

Parameters:
- NCH, 4, number of input channels (2..16).
- WIDTH, 71, width of each channel and of the output.
- SEL_WIDTH, 2, select width; must satisfy 2**SEL_WIDTH >= NCH.
- BLANK_CYCLES, 4, cycles dbg_o is forced to zero after a channel switch (1..255).
- DEFAULT_SEL, 0, channel active after reset.

Ports:
- clk_i  in  1  ILA/debug clock; one clock domain for the whole block.
- rst_i  in  1  asynchronous, active-high reset.
- dbg_i  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel_i  in  SEL_WIDTH  requested channel.
- sel_wr_i  in  1  single-cycle strobe; sel_i is sampled when high.
- freeze_i  in  1  hold dbg_o at its current value while high.
- trig_mask_i  in  WIDTH  bits watched by the change detector.
- dbg_o  out  WIDTH  selected, registered debug bus.
- valid_o  out  1  high when dbg_o carries live channel data.
- sel_o  out  SEL_WIDTH  currently active channel.
- busy_o  out  1  high while a switch is in progress (BLANK state).
- sel_err_o  out  1  sticky; set by a rejected select write.
- trig_o  out  1  one-cycle pulse on a masked-bit change.

Behaviour:
- Reset values (async): dbg_o=0, valid_o=0, sel_o=DEFAULT_SEL, busy_o=0, sel_err_o=0, trig_o=0. FSM enters BLANK with count=BLANK_CYCLES, so valid_o rises BLANK_CYCLES+1 cycles after rst_i deasserts.
- Pipeline:
  - Stage 1 registers all of dbg_i.
  - Stage 2 muxes stage 1 by sel_o into dbg_o.
  - Latency from dbg_i to dbg_o is 2 cycles in ACTIVE.
- Select write, on a cycle where sel_wr_i=1:
  - If sel_i >= NCH: the write is ignored and sel_err_o is set. sel_err_o is cleared only by reset or by a later in-range write.
  - If sel_i == sel_o: no effect apart from clearing sel_err_o. No blanking.
  - Otherwise: sel_o <= sel_i at the next edge, sel_err_o cleared, FSM goes to BLANK.
- FSM:
  - ACTIVE: valid_o=1; dbg_o follows stage 2 unless frozen. An accepted switch moves to BLANK with count=BLANK_CYCLES.
  - BLANK: dbg_o=0, valid_o=0, busy_o=1; count decrements each cycle. When count reaches 1, the next state is ACTIVE.
  - A new accepted write during BLANK updates sel_o and reloads count to BLANK_CYCLES, restarting the blank.
  - Exactly BLANK_CYCLES zero cycles follow the last accepted write. The first live word is from the new channel; no stale data leaks.
- Freeze:
  - freeze_i=1 in ACTIVE: dbg_o and valid_o hold; trig_o is suppressed.
  - freeze_i in BLANK has no effect; blanking still completes.
  - On release, dbg_o resumes with the current stage-2 data on the next edge.
  - Select writes are still accepted while frozen.
- Trigger:
  - trig_o=1 for one cycle when ((stage2 XOR dbg_o_prev) AND trig_mask_i) != 0, with state ACTIVE and not frozen. dbg_o_prev is the previous live output.
  - trig_o is registered and aligned with the dbg_o cycle that shows the change.
  - The first ACTIVE cycle after BLANK never triggers; the comparison baseline is reloaded.
- Reset mid-switch: everything returns to the reset values above; the pending select is discarded.

Optional Feature:
- Macro DEBUG_CHAN_MUX_TRIGCNT_EN.
- When defined: extra output trig_cnt_o, 16 bits, reset 0.
  - Increments on each trig_o pulse and saturates at 16'hFFFF.
  - Cleared to 0 on every accepted channel switch, on the same edge sel_o updates.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release with DEFAULT_SEL=0, BLANK_CYCLES=4, channel 0 = 71'h5A → dbg_o=0 and valid_o=0 for 4 cycles; dbg_o=71'h5A with valid_o=1 from cycle 5; sel_o=0.
- In ACTIVE, pulse sel_wr_i with sel_i=2, ch2=71'h123 → sel_o=2 next edge; busy_o=1 and dbg_o=0 for exactly 4 cycles; then dbg_o=71'h123 with no ch0 value seen.
- NCH=3, write sel_i=3 → sel_o unchanged, no blanking, sel_err_o=1 and held; a later write sel_i=1 clears sel_err_o and switches.
- Write sel_i=1 then sel_i=2 two cycles later → blanking restarts: 4 zero cycles after the second write; final sel_o=2.
- trig_mask_i=71'h1, toggle ch0 bit0 then bit1 → trig_o pulses once, 2 cycles after the bit0 change; no pulse for bit1. With freeze_i=1, a bit0 toggle gives no pulse and dbg_o held.
- With DEBUG_CHAN_MUX_TRIGCNT_EN, cause 5 triggers → trig_cnt_o=5; switch channel → trig_cnt_o=0.
